// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: opcode encodings and the multiply sequencer state type.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_EQ  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mulseq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller that borrows the shared ALU for one ADD per cycle
// while busy, producing the low DATA_WIDTH bits of in_a*in_b.
module alu_mul_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_a,
  input  logic [DATA_WIDTH-1:0]    in_b,
  output logic [DATA_WIDTH-1:0]    alu_src_a,
  output logic [DATA_WIDTH-1:0]    alu_src_b,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_product,
  output logic                     busy
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

  mulseq_state_t         r_state;
  mulseq_state_t         w_next_state;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [CW-1:0]         r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc    <= '0;
            r_mcand  <= in_a;
            r_mplier <= in_b;
            r_count  <= '0;
          end
        end
        RUN: begin
          // Fixed DATA_WIDTH iterations; no early exit when the multiplier runs out of ones.
          if (r_mplier[0]) begin
            r_acc <= alu_result;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state  = r_state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_product   = '0;
    busy          = 1'b0;
    alu_src_a     = '0;
    alu_src_b     = '0;
    alu_operation = OPCODE_LENGTH'(ALU_ADD);
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        alu_src_a = r_acc;
        alu_src_b = r_mcand;
        if (r_count == LAST_COUNT) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        out_valid   = 1'b1;
        out_product = r_acc;
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed and random checks of alu_mul_sequencer wired to a behavioural ALU.
module tb_alu_mul_sequencer;
  import alu_ctrl_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [DW-1:0] alu_src_a;
  logic [DW-1:0] alu_src_b;
  logic [3:0]    alu_operation;
  logic [DW-1:0] alu_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_product;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_operation)
      ALU_AND: alu_result = alu_src_a & alu_src_b;
      ALU_ADD: alu_result = alu_src_a + alu_src_b;
      ALU_SUB: alu_result = alu_src_a - alu_src_b;
      ALU_EQ:  alu_result = {31'b0, alu_src_a == alu_src_b};
      default: alu_result = '0;
    endcase
  end

  alu_mul_sequencer #(.DATA_WIDTH(DW), .OPCODE_LENGTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_operation(alu_operation),
    .alu_result   (alu_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .busy         (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // lat counts edges from the accept edge (counted as 1) up to the edge that raises out_valid.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input int stall,
                        output logic [DW-1:0] p, output int lat, output bit to);
    int n;
    to  = 1'b0;
    lat = 0;
    p   = '0;
    n   = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      to = 1'b1;
      return;
    end
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      to = 1'b1;
      return;
    end
    repeat (stall) tick();
    p = out_product;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b1;
    in_a = 32'd3;
    in_b = 32'd3;
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               in_ready, out_valid, busy);
    end
    checks++;
    if (out_product !== 32'd0 || alu_src_a !== 32'd0 || alu_src_b !== 32'd0 ||
        alu_operation !== 4'b0010) begin
      errors++;
      $display("FAIL reset_data: product=%h src_a=%h src_b=%h op=%b, required 0 0 0 0010",
               out_product, alu_src_a, alu_src_b, alu_operation);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic;
    int lat;
    int bad;
    bad = 0;
    in_a = 32'd6;
    in_b = 32'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (busy !== 1'b1 || alu_operation !== 4'b0010 || in_ready !== 1'b0) bad++;
      tick();
      lat++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL run_signals: %0d RUN cycles with busy/op/in_ready wrong, required 0", bad);
    end
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL latency_6x7: edges=%0d, required 33", lat);
    end
    checks++;
    if (out_product !== 32'd42 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL product_6x7: product=%0d busy=%b in_ready=%b, required 42 0 0",
               out_product, busy, in_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_product !== 32'd0) begin
      errors++;
      $display("FAIL after_handshake: out_valid=%b in_ready=%b product=%h, required 0 1 0",
               out_valid, in_ready, out_product);
    end
  endtask

  task automatic test_corners;
    logic [DW-1:0] va [3];
    logic [DW-1:0] vb [3];
    logic [DW-1:0] ve [3];
    logic [DW-1:0] p;
    int lat;
    bit to;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; ve[0] = 32'h0000_0001;
    va[1] = 32'h8000_0000; vb[1] = 32'h0000_0002; ve[1] = 32'h0000_0000;
    va[2] = 32'h1234_5678; vb[2] = 32'h0000_0000; ve[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 0, p, lat, to);
      checks++;
      if (to || p !== ve[i] || lat !== 33) begin
        errors++;
        $display("FAIL corner_%0d: product=%h lat=%0d timeout=%b, required %h 33 0",
                 i, p, lat, to, ve[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    int bad;
    in_a = 32'd10;
    in_b = 32'd10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%b, required 1", out_valid);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = 32'd77 + i;
      in_b = 32'd5;
      tick();
      if (out_valid !== 1'b1 || out_product !== 32'd100 || in_ready !== 1'b0 || busy !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d stalled cycles not holding product, required 0", bad);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_capture: busy=%b in_ready=%b, required 0 1", busy, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    in_a = 32'd3;
    in_b = 32'd5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (out_product !== 32'd15 || n !== 33) begin
      errors++;
      $display("FAIL b2b_first: product=%0d lat=%0d, required 15 33", out_product, n);
    end
    in_a = 32'd9;
    in_b = 32'd9;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               out_valid, in_ready, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b, required 1", busy);
    end
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (out_product !== 32'd81 || n !== 33) begin
      errors++;
      $display("FAIL b2b_second: product=%0d lat=%0d, required 81 33", out_product, n);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    logic [DW-1:0] p;
    int lat;
    int bad;
    bit to;
    in_a = 32'd7;
    in_b = 32'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
        alu_src_a !== 32'd0 || alu_src_b !== 32'd0 || alu_operation !== 4'b0010) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b busy=%b in_ready=%b src_a=%h src_b=%h op=%b, required 0 0 1 0 0 0010",
               out_valid, busy, in_ready, alu_src_a, alu_src_b, alu_operation);
    end
    tick();
    tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_product !== 32'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stale_result: %0d cycles showing activity after abort, required 0", bad);
    end
    run_op(32'd4, 32'd4, 0, p, lat, to);
    checks++;
    if (to || p !== 32'd16 || lat !== 33) begin
      errors++;
      $display("FAIL post_abort_4x4: product=%0d lat=%0d timeout=%b, required 16 33 0",
               p, lat, to);
    end
  endtask

  task automatic test_random;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] e;
    logic [DW-1:0] p;
    int lat;
    bit to;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      e = a * b;
      run_op(a, b, int'($urandom_range(0, 3)), p, lat, to);
      checks++;
      if (to || p !== e) begin
        errors++;
        $display("FAIL random_%0d: %h*%h product=%h timeout=%b, required %h 0", i, a, b, p, to, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
